microstep_pwm_multi: RTL and testbench

MICROSTEP_PWM_MULTI -- requirements
Module: microstep_pwm_multi

---
 rtl/microstep_pwm_multi.sv | 112 +++++++++++
 tb/tb_microstep_pwm_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/microstep_pwm_multi.sv
// Multi-channel microstep phase accumulator: a shared free-running counter feeds per-channel
// micro/nano dither terms added to a double-buffered phase; the integer part is registered out.
module microstep_pwm_multi #(
  parameter int NUM_CH          = 2,
  parameter int PHASE_WIDTH     = 32,
  parameter int Q_WIDTH         = 16,
  parameter int OUTPUT_WIDTH    = PHASE_WIDTH - Q_WIDTH,
  parameter int MICROSTEP_WIDTH = 12,
  parameter int STAGGER         = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2*NUM_CH-1:0]             mode,
  input  logic [NUM_CH-1:0]               async_en,
  input  logic [PHASE_WIDTH*NUM_CH-1:0]   s_phase,
  input  logic [NUM_CH-1:0]               s_valid,
  output logic [NUM_CH-1:0]               s_ready,
  output logic [NUM_CH-1:0]               update,
  output logic [NUM_CH-1:0]               m_update,
  output logic [OUTPUT_WIDTH*NUM_CH-1:0]  out_val
);
  localparam int M       = MICROSTEP_WIDTH;
  localparam int N       = (Q_WIDTH > M) ? Q_WIDTH - M : 1;
  localparam int SPACING = (1 << M) / NUM_CH;

  logic [M-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + M'(1);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [M-1:0] OFFSET = (STAGGER != 0) ? M'(c * SPACING) : '0;

    logic [M-1:0]             mc;
    logic [1:0]               ch_mode;
    logic [N-1:0]             nano_cnt;
    logic [N-1:0]             nano_rev;
    logic [PHASE_WIDTH-1:0]   active;
    logic [PHASE_WIDTH-1:0]   shadow;
    logic [PHASE_WIDTH-1:0]   micro_raw;
    logic [PHASE_WIDTH-1:0]   nano_raw;
    logic [PHASE_WIDTH-1:0]   micro;
    logic [PHASE_WIDTH-1:0]   nano;
    logic [PHASE_WIDTH-1:0]   sum;
    logic [OUTPUT_WIDTH-1:0]  out_next;
    logic [OUTPUT_WIDTH-1:0]  out_q;
    logic                     full;
    logic                     full_next;
    logic                     rdy;
    logic                     mupd;
    logic                     xfer;
    logic                     accept;

    assign mc        = cnt + OFFSET;
    assign update[c] = &mc;
    assign ch_mode   = mode[2*c +: 2];

    for (genvar i = 0; i < N; i++) begin : g_rev
      assign nano_rev[i] = nano_cnt[N-1-i];
    end

    if (Q_WIDTH > M) begin : g_fine
      assign micro_raw = PHASE_WIDTH'(mc) << (Q_WIDTH - M);
      assign nano_raw  = PHASE_WIDTH'(nano_rev);
    end else begin : g_coarse
      assign micro_raw = PHASE_WIDTH'(mc >> (M - Q_WIDTH));
      assign nano_raw  = '0;
    end

    assign micro    = (ch_mode == 2'b00) ? '0 : micro_raw;
    assign nano     = ch_mode[1] ? nano_raw : '0;
    assign sum      = active + micro + nano;
    assign out_next = OUTPUT_WIDTH'(sum >> Q_WIDTH);

    // rdy tracks ~full, so an accept can never land in the same cycle as a transfer
    assign xfer   = full & (update[c] | async_en[c]);
    assign accept = s_valid[c] & rdy;

    always_comb begin
      full_next = full;
      if (xfer)        full_next = 1'b0;
      else if (accept) full_next = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        active   <= '0;
        shadow   <= '0;
        full     <= 1'b0;
        rdy      <= 1'b0;
        nano_cnt <= '0;
        out_q    <= '0;
        mupd     <= 1'b0;
      end else begin
        full <= full_next;
        rdy  <= ~full_next;
        if (accept)    shadow   <= s_phase[c*PHASE_WIDTH +: PHASE_WIDTH];
        if (xfer)      active   <= shadow;
        if (update[c]) nano_cnt <= nano_cnt + N'(1);
        out_q <= out_next;
        mupd  <= update[c];
      end
    end

    assign s_ready[c]                            = rdy;
    assign m_update[c]                           = mupd;
    assign out_val[c*OUTPUT_WIDTH +: OUTPUT_WIDTH] = out_q;
  end

endmodule

// File: tb/tb_microstep_pwm_multi.sv
// Bench for microstep_pwm_multi (2 channels, M=12, Q=16): cycle scoreboard plus directed
// checks of update timing, load handshake, duty counts, nano dither and reset discard.
module tb_microstep_pwm_multi;
  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [3:0]  mode     = '0;
  logic [1:0]  async_en = '0;
  logic [63:0] s_phase  = '0;
  logic [1:0]  s_valid  = '0;
  logic [1:0]  s_ready;
  logic [1:0]  update;
  logic [1:0]  m_update;
  logic [31:0] out_val;

  always #5 clk = ~clk;

  microstep_pwm_multi #(
    .NUM_CH(2), .PHASE_WIDTH(32), .Q_WIDTH(16), .OUTPUT_WIDTH(16),
    .MICROSTEP_WIDTH(12), .STAGGER(1)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .async_en(async_en),
    .s_phase(s_phase), .s_valid(s_valid), .s_ready(s_ready),
    .update(update), .m_update(m_update), .out_val(out_val)
  );

  typedef struct packed {
    logic [15:0] out1;
    logic [15:0] out0;
    logic [1:0]  upd;
    logic [1:0]  mupd;
    logic [1:0]  rdy;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  last_exp;
  int   total = 0;
  int   bad   = 0;

  logic [11:0] m_cnt;
  logic [3:0]  m_nano[2];
  logic [31:0] m_act[2];
  logic [31:0] m_shd[2];
  logic        m_full[2];
  logic        m_rdy[2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Predict what the DUT shows after the coming edge, given the inputs now applied.
  task automatic model_step();
    sb_t e;
    e = '0;
    if (reset) begin
      m_cnt = '0;
      for (int c = 0; c < 2; c++) begin
        m_nano[c] = '0; m_act[c] = '0; m_shd[c] = '0; m_full[c] = 1'b0; m_rdy[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        logic [11:0] mc;
        logic [31:0] sum;
        logic [1:0]  md;
        logic        u;
        mc  = m_cnt + 12'(c * 2048);
        u   = (mc == 12'd4095);
        md  = mode[2*c +: 2];
        sum = m_act[c];
        if (md != 2'b00) sum = sum + {16'b0, mc, 4'b0};
        if (md[1])       sum = sum + {28'b0, rev4(m_nano[c])};
        if (c == 0) e.out0 = sum[31:16];
        else        e.out1 = sum[31:16];
        e.mupd[c] = u;
        if (m_full[c] && (u || async_en[c])) begin
          m_act[c] = m_shd[c]; m_full[c] = 1'b0;
        end else if (s_valid[c] && m_rdy[c]) begin
          m_shd[c] = s_phase[32*c +: 32]; m_full[c] = 1'b1;
        end
        m_rdy[c] = !m_full[c];
        if (u) m_nano[c] = m_nano[c] + 4'd1;
      end
      m_cnt = m_cnt + 12'd1;
    end
    for (int c = 0; c < 2; c++) begin
      e.upd[c] = ((m_cnt + 12'(c * 2048)) == 12'd4095);
      e.rdy[c] = m_rdy[c];
    end
    sb_q.push_back(e);
  endtask

  task automatic tick();
    sb_t got;
    model_step();
    @(posedge clk);
    #1;
    got = {out_val[31:16], out_val[15:0], update, m_update, s_ready};
    check_val("sb_depth", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      last_exp = sb_q.pop_front();
      check_val("cycle", 64'(got), 64'(last_exp));
    end
  endtask

  initial begin
    int first0, first1, n0, found, rdy_hi, ones, other, n_ffff, n_zero;
    int got0, exp0, got1, exp1, rec, alt;
    logic prev_mu1, prev_bit;

    reset = 1'b1;
    repeat (3) tick();
    check_val("rst_out", 64'(out_val), 64'd0);
    check_val("rst_rdy", 64'(s_ready), 64'd0);
    reset = 1'b0;
    tick();
    check_val("rdy_after_rst", 64'(s_ready), 64'd3);

    // ch1 load waits for its update; reset while pending must discard it
    s_phase[63:32] = 32'h1234_0000; s_valid = 2'b10;
    tick();
    s_valid = 2'b00;
    tick();
    check_val("ch1_full", 64'(s_ready[1]), 64'd0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_val("rdy_after_rst2", 64'(s_ready[1]), 64'd1);

    first0 = -1; first1 = -1; n0 = 0;
    for (int i = 2; i <= 8193; i++) begin
      tick();
      if (update[0]) begin
        n0++;
        if (first0 < 0) first0 = i;
      end
      if (update[1] && first1 < 0) first1 = i;
      if (i == 4096) check_val("mupd0_lag", 64'(m_update[0]), 64'd1);
      if (i == 2100) check_val("ch1_discard", 64'(out_val[31:16]), 64'd0);
    end
    check_val("upd0_first", 64'(first0), 64'd4095);
    check_val("upd1_first", 64'(first1), 64'd2047);
    check_val("upd0_count", 64'(n0), 64'd2);

    // synchronous load on ch0, mode hold
    s_phase[31:0] = 32'h0001_0000; s_valid = 2'b01;
    tick();
    s_valid = 2'b00;
    found = 0; rdy_hi = 0;
    for (int i = 0; i < 5000 && found == 0; i++) begin
      tick();
      if (update[0]) found = 1;
      else if (s_ready[0]) rdy_hi++;
    end
    check_val("upd0_seen", 64'(found), 64'd1);
    check_val("rdy0_held_low", 64'(rdy_hi), 64'd0);
    tick();
    check_val("rdy0_back", 64'(s_ready[0]), 64'd1);
    check_val("sync_pre", 64'(out_val[15:0]), 64'd0);
    tick();
    check_val("sync_post", 64'(out_val[15:0]), 64'd1);

    // micro duty on ch0
    async_en = 2'b11; mode = 4'b0001;
    s_phase[31:0] = 32'h0000_F000; s_valid = 2'b01;
    tick();
    s_valid = 2'b00;
    repeat (3) tick();
    ones = 0; other = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (out_val[15:0] == 16'd1) ones++;
      else if (out_val[15:0] != 16'd0) other++;
    end
    check_val("duty_ones", 64'(ones), 64'd3840);
    check_val("duty_other", 64'(other), 64'd0);

    // wrap on ch1
    mode = 4'b0101;
    s_phase[63:32] = 32'hFFFF_FFFF; s_valid = 2'b10;
    tick();
    s_valid = 2'b00;
    repeat (3) tick();
    n_ffff = 0; n_zero = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (out_val[31:16] == 16'hFFFF) n_ffff++;
      if (out_val[31:16] == 16'h0000) n_zero++;
    end
    check_val("wrap_ffff", 64'(n_ffff), 64'd1);
    check_val("wrap_zero", 64'(n_zero), 64'd4095);

    // async load on ch0: new value visible two cycles after accept
    mode = 4'b0100;
    repeat (2) tick();
    s_phase[31:0] = 32'h0005_0000; s_valid = 2'b01;
    tick();
    s_valid = 2'b00;
    check_val("async_rdy_low", 64'(s_ready[0]), 64'd0);
    tick();
    check_val("async_pre", 64'(out_val[15:0]), 64'd0);
    tick();
    check_val("async_post", 64'(out_val[15:0]), 64'd5);

    // micro+nano on both channels
    mode = 4'b1110;
    s_phase = {32'h0000_FFF8, 32'h0000_FFF0}; s_valid = 2'b11;
    tick();
    s_valid = 2'b00;
    repeat (3) tick();
    got0 = 0; exp0 = 0; got1 = 0; exp1 = 0; rec = 0; alt = 0;
    prev_mu1 = 1'b0; prev_bit = 1'b0;
    for (int i = 0; i < 8 * 4096; i++) begin
      tick();
      if (out_val[15:0]  == 16'd1) got0++;
      if (last_exp.out0  == 16'd1) exp0++;
      if (out_val[31:16] == 16'd1) got1++;
      if (last_exp.out1  == 16'd1) exp1++;
      if (prev_mu1) begin
        rec++;
        if (rec > 1 && out_val[16] != prev_bit) alt++;
        prev_bit = out_val[16];
      end
      prev_mu1 = m_update[1];
    end
    check_val("nano_ones0", 64'(got0), 64'(exp0));
    check_val("nano_ones1", 64'(got1), 64'(exp1));
    check_val("nano_periods", 64'(rec >= 7), 64'd1);
    check_val("nano_alternate", 64'(alt), 64'(rec - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
